// File: rtl/timer_task_scheduler_pkg.sv
// Shared types and constants for the periodic task scheduler.
package sched_pkg;

  typedef enum logic {IDLE, GRANT} sched_state_t;

  localparam int DEFAULT_ACK_TIMEOUT = 1024;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_task_scheduler_rr_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping.
module rr_pick
  import sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = ch_idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any
);

  int idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = W'(idx);
      end
    end
  end

endmodule

// File: rtl/timer_task_scheduler.sv
// Shares the periodic timer tick between NUM_CH tasks and issues one request at a time.
// state | meaning
// IDLE  | no request outstanding, picks next pending channel
// GRANT | req_valid held until req_ack or ack timeout
module timer_task_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      tick,
  output logic                      tmr_start,
  output logic                      tmr_restart,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_period,
  output logic                      req_valid,
  output logic [$clog2(NUM_CH)-1:0] req_id,
  input  logic                      req_ack,
  output logic [NUM_CH-1:0]         pending,
  output logic [NUM_CH-1:0]         overrun,
  input  logic                      overrun_clr,
  output logic                      timeout_err
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int TO_W  = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  sched_state_t     state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick;
  logic             any;
  logic [TO_W-1:0]  to_cnt;

  logic [CNT_W-1:0] period [NUM_CH];
  logic [CNT_W-1:0] cnt    [NUM_CH];

  logic              en_rise;
  logic              grant_done;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] count_en;
  logic [NUM_CH-1:0] due;
  logic [NUM_CH-1:0] clr_mask;

  assign en_rise    = en & ~tmr_start;
  assign grant_done = (state == GRANT) && (req_ack || (to_cnt == TO_LAST));

  // A config write or an enable edge resets the counter, so neither may also make the channel due.
  always_comb begin
    wr_sel   = '0;
    count_en = '0;
    due      = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i]   = cfg_we && (cfg_ch == IDX_W'(i));
      count_en[i] = en && tick && !en_rise && !wr_sel[i] && (period[i] != '0);
      due[i]      = count_en[i] && (cnt[i] == period[i] - CNT_W'(1));
      clr_mask[i] = grant_done && (req_id == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_start   <= 1'b0;
      tmr_restart <= 1'b0;
      pending     <= '0;
      overrun     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      tmr_start   <= en;
      tmr_restart <= en_rise;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_sel[i]) begin
          period[i] <= cfg_period;
          cnt[i]    <= '0;
        end else if (en_rise) begin
          cnt[i] <= '0;
        end else if (count_en[i]) begin
          cnt[i] <= due[i] ? '0 : cnt[i] + CNT_W'(1);
        end
      end
      pending <= (pending | due) & ~clr_mask;
      overrun <= (overrun & ~{NUM_CH{overrun_clr}}) | (due & pending);
    end
  end

  rr_pick #(.N(NUM_CH), .W(IDX_W)) u_rr_pick (
    .req   (pending),
    .ptr   (ptr),
    .grant (pick),
    .any   (any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= IDX_W'(NUM_CH - 1);
      req_valid   <= 1'b0;
      req_id      <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            req_id    <= pick;
            req_valid <= 1'b1;
            to_cnt    <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (req_ack) begin
            req_valid <= 1'b0;
            ptr       <= req_id;
            state     <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            req_valid   <= 1'b0;
            ptr         <= req_id;
            state       <= IDLE;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_task_scheduler.sv
// Directed bench for timer_task_scheduler with hand-computed expectations.
module tb_timer_task_scheduler;

  logic       clk = 1'b0;
  logic       reset, en, tick, cfg_we, req_ack, overrun_clr;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period;
  logic       tmr_start, tmr_restart, req_valid, timeout_err;
  logic [1:0] req_id;
  logic [3:0] pending, overrun;

  int passed = 0;
  int total  = 0;

  timer_task_scheduler #(.NUM_CH(4), .CNT_W(8), .ACK_TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .tick        (tick),
    .tmr_start   (tmr_start),
    .tmr_restart (tmr_restart),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_ack     (req_ack),
    .pending     (pending),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] p);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = p;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Wait (bounded) for a request, check its id, ack it for one cycle, check it drops.
  task automatic serve(input logic [1:0] exp_id, input string tag);
    int n = 0;
    while (!req_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, req_valid}, 32'd1);
    chk({tag, "_id"}, {30'd0, req_id}, {30'd0, exp_id});
    req_ack = 1'b1;
    step();
    req_ack = 1'b0;
    chk({tag, "_drop"}, {31'd0, req_valid}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; en = 1'b0; tick = 1'b0; cfg_we = 1'b0; req_ack = 1'b0;
    overrun_clr = 1'b0; cfg_ch = '0; cfg_period = '0;
    step(); step();
    reset = 1'b0;
    chk("reset_outputs", {19'd0, req_valid, req_id, pending, overrun, timeout_err, tmr_start, tmr_restart}, 32'd0);

    // periods: ch0=1, ch1=2
    cfg(2'd0, 8'd1);
    cfg(2'd1, 8'd2);
    en = 1'b1;
    step();
    chk("restart_pulse", {30'd0, tmr_start, tmr_restart}, 32'd3);
    step();
    chk("restart_end", {30'd0, tmr_start, tmr_restart}, 32'd2);
    do_tick();
    chk("pend_t1", {28'd0, pending}, 32'h1);
    chk("rv_before", {31'd0, req_valid}, 32'd0);
    step();
    chk("rv_latency", {31'd0, req_valid}, 32'd1);
    serve(2'd0, "p_g1");
    do_tick();
    serve(2'd1, "p_g2");
    serve(2'd0, "p_g3");
    do_tick();
    serve(2'd0, "p_g4");
    do_tick();
    serve(2'd1, "p_g5");
    serve(2'd0, "p_g6");
    chk("p_empty", {28'd0, pending}, 32'h0);

    // round-robin from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) cfg(2'(c), 8'd1);
    do_tick();
    chk("rr_pend", {28'd0, pending}, 32'hF);
    serve(2'd0, "rr_a0");
    serve(2'd1, "rr_a1");
    serve(2'd2, "rr_a2");
    serve(2'd3, "rr_a3");
    do_tick();
    serve(2'd0, "rr_b0");
    serve(2'd1, "rr_b1");
    serve(2'd2, "rr_b2");
    serve(2'd3, "rr_b3");

    // overrun on ch2
    cfg(2'd0, 8'd0);
    cfg(2'd1, 8'd0);
    cfg(2'd3, 8'd0);
    do_tick();
    do_tick();
    chk("ovr_set", {28'd0, overrun}, 32'h4);
    chk("ovr_pend", {28'd0, pending}, 32'h4);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("ovr_clr", {28'd0, overrun}, 32'h0);
    tick = 1'b1; overrun_clr = 1'b1;
    step();
    tick = 1'b0; overrun_clr = 1'b0;
    chk("ovr_set_wins", {28'd0, overrun}, 32'h4);
    serve(2'd2, "ovr_srv");
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;

    // ack timeout on ch1, then ch2 is granted
    cfg(2'd1, 8'd1);
    do_tick();
    n = 0;
    while (!req_valid && n < 20) begin step(); n++; end
    chk("to_id", {30'd0, req_id}, 32'd1);
    n = 0;
    while (!timeout_err && n < 40) begin step(); n++; end
    chk("to_cycles", n, 32'd16);
    chk("to_state", {26'd0, timeout_err, req_valid, pending}, 32'h24);
    step();
    chk("to_pulse_end", {31'd0, timeout_err}, 32'd0);
    chk("to_next", {29'd0, req_valid, req_id}, 32'h6);
    serve(2'd2, "to_srv");

    // enable edge clears counters; disabled scheduler still serves pending
    cfg(2'd1, 8'd3);
    cfg(2'd2, 8'd0);
    do_tick();
    do_tick();
    chk("en_pre", {28'd0, pending}, 32'h0);
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    chk("en_restart", {31'd0, tmr_restart}, 32'd1);
    step();
    chk("en_restart_end", {31'd0, tmr_restart}, 32'd0);
    do_tick();
    chk("en_cleared", {28'd0, pending}, 32'h0);
    do_tick();
    do_tick();
    chk("en_due3", {28'd0, pending}, 32'h2);
    en = 1'b0;
    serve(2'd1, "en_off_srv");
    cfg(2'd0, 8'd1);
    do_tick();
    do_tick();
    do_tick();
    chk("en_off_nopend", {28'd0, pending}, 32'h0);

    // reset in the middle of a grant
    en = 1'b1;
    step();
    do_tick();
    n = 0;
    while (!req_valid && n < 20) begin step(); n++; end
    chk("mid_rv", {31'd0, req_valid}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_reset", {19'd0, req_valid, req_id, pending, overrun, timeout_err, tmr_start, tmr_restart}, 32'd0);
    req_ack = 1'b1;
    step();
    req_ack = 1'b0;
    chk("late_ack", {22'd0, req_valid, req_id, pending, timeout_err}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
